registro_universal: RTL

REGISTRO_UNIVERSAL -- requirements
Module: registro_universal

---
 rtl/registro_universal.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/registro_universal.sv
// Universal shift register: logical/arithmetic shift, rotate and parallel load,
// plus a serial burst mode that streams WIDTH bits out through S_OUT.
module registro_universal #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [2:0]       MODO,
  input  logic [SHW-1:0]   SHAMT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_SHIFTING = 1'b1;

  localparam logic [2:0] M_LSH   = 3'b001;
  localparam logic [2:0] M_ROT   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ASH   = 3'b100;
  localparam logic [2:0] M_BURST = 3'b101;

  localparam logic [SHW:0]   WIDTH_L = (SHW+1)'(WIDTH);
  localparam logic [SHW-1:0] K_MAX   = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] K_ZERO  = SHW'(0);
  localparam logic [SHW-1:0] K_ONE   = SHW'(1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

  // Returns {last bit out, shifted value}; k must be non-zero.
  function automatic logic [WIDTH:0] f_shift(
    input logic [WIDTH-1:0] q,
    input logic [SHW-1:0]   k,
    input logic             dir,
    input logic             fill,
    input logic             rot
  );
    logic [2*WIDTH-1:0] t;
    logic [WIDTH-1:0]   ext;
    logic [WIDTH-1:0]   probe;
    logic [WIDTH-1:0]   res;
    logic               so;
    ext = rot ? q : {WIDTH{fill}};
    if (dir) begin
      t     = {ext, q} >> k;
      res   = t[WIDTH-1:0];
      probe = q >> (k - K_ONE);
      so    = probe[0];
    end else begin
      t     = {q, ext} << k;
      res   = t[2*WIDTH-1:WIDTH];
      probe = q << (k - K_ONE);
      so    = probe[WIDTH-1];
    end
    return {so, res};
  endfunction

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic             r_done;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_nxt;
  logic [0:0]       w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_dir_nxt;
  logic             w_done_nxt;
  logic [SHW:0]     w_amt_ext;
  logic [SHW:0]     w_rot_ext;
  logic [SHW-1:0]   w_k_sh;
  logic [SHW-1:0]   w_k_rot;
  logic [WIDTH:0]   w_res;

  // Amount conditioning: shifts saturate at WIDTH-1, rotates wrap modulo WIDTH.
  always_comb begin
    w_amt_ext = {1'b0, SHAMT};
    if (w_amt_ext >= WIDTH_L) begin
      w_k_sh    = K_MAX;
      w_rot_ext = w_amt_ext - WIDTH_L;
    end else begin
      w_k_sh    = SHAMT;
      w_rot_ext = w_amt_ext;
    end
    w_k_rot = w_rot_ext[SHW-1:0];
  end

  // Next-state decode for the datapath and the burst FSM.
  always_comb begin
    w_q_nxt     = r_q;
    w_sout_nxt  = r_sout;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;
    w_res       = {r_sout, r_q};
    if (!ENB) begin
      w_done_nxt = 1'b0;
    end else if (r_state == ST_SHIFTING) begin
      w_res      = f_shift(r_q, K_ONE, r_dir, S_IN, 1'b0);
      w_q_nxt    = w_res[WIDTH-1:0];
      w_sout_nxt = w_res[WIDTH];
      w_cnt_nxt  = r_cnt - CNT_ONE;
      if (r_cnt == CNT_ONE) begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = ST_SHIFTING;
      end
    end else begin
      case (MODO)
        M_LSH: begin
          if (w_k_sh != K_ZERO) begin
            w_res      = f_shift(r_q, w_k_sh, DIR, S_IN, 1'b0);
            w_q_nxt    = w_res[WIDTH-1:0];
            w_sout_nxt = w_res[WIDTH];
          end else begin
            w_q_nxt = r_q;
          end
        end
        M_ROT: begin
          if (w_k_rot != K_ZERO) begin
            w_res      = f_shift(r_q, w_k_rot, DIR, 1'b0, 1'b1);
            w_q_nxt    = w_res[WIDTH-1:0];
            w_sout_nxt = w_res[WIDTH];
          end else begin
            w_q_nxt = r_q;
          end
        end
        M_LOAD: w_q_nxt = D;
        M_ASH: begin
          if (w_k_sh != K_ZERO) begin
            w_res      = f_shift(r_q, w_k_sh, DIR, DIR & r_q[WIDTH-1], 1'b0);
            w_q_nxt    = w_res[WIDTH-1:0];
            w_sout_nxt = w_res[WIDTH];
          end else begin
            w_q_nxt = r_q;
          end
        end
        M_BURST: begin
          w_q_nxt     = D;
          w_cnt_nxt   = CNT_MAX;
          w_dir_nxt   = DIR;
          w_state_nxt = ST_SHIFTING;
        end
        default: w_q_nxt = r_q;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= {WIDTH{1'b0}};
      r_sout  <= 1'b0;
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_dir   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_q     <= w_q_nxt;
      r_sout  <= w_sout_nxt;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign Q     = r_q;
  assign S_OUT = r_sout;
  assign BUSY  = (r_state == ST_SHIFTING);
  assign DONE  = r_done;

endmodule
